// File: rtl/eth_pkg.sv
// Shared Ethernet RX/TX constants and the receive state encoding.
// No logic; pure declarations.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PREAMBLE  = 2'd2,
        DATA      = 2'd3
    } rx_state_e;

endpackage

// File: rtl/crc32_d8_next.sv
// CRC-32 (04C11DB7) one-byte step, byte consumed bit 0 first; latency: combinational.
// No flow control; result is valid whenever the inputs are.
module crc32_d8_next
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] next_o
);

    logic [31:0] c;
    logic        fb;

    // Feeding data_i[0] first is the same as bit-reversing the byte into an MSB-first shifter.
    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data_i[i];
            c  = {c[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
        end
        next_o = c;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX frame checker: strips preamble/SFD, checks FCS residue and length, forwards frame minus FCS.
// Latency: byte k leaves as byte k+4 arrives; no backpressure, the PHY stream cannot be stalled.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rx_data,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             status_valid,
    output logic             frame_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic             phy_err,
    output logic [15:0]      frame_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    rx_state_e        state_q, state_d;
    logic [31:0]      crc_q;
    logic [31:0]      crc_next;
    logic [3:0][7:0]  dly_q;
    logic [15:0]      len_q;
    logic             phy_q;

    logic             out_valid_q, out_sof_q;
    logic [7:0]       out_data_q;
    logic             status_valid_q, frame_ok_q, crc_err_q, len_err_q, phy_err_q;
    logic [15:0]      frame_len_q;
    logic [CNT_W-1:0] good_q, bad_q;

    logic             start_frame, take_byte, end_frame;
    logic             short_w, crc_bad_w, len_bad_w, ok_w;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (!rx_dv) state_d = IDLE;
            end
            IDLE: begin
                if (rx_dv) state_d = (rx_data == ETH_PREAMBLE) ? PREAMBLE : WAIT_IDLE;
            end
            PREAMBLE: begin
                if (rx_dv && rx_data == ETH_PREAMBLE) begin
                    state_d = PREAMBLE;
                end else if (rx_dv && rx_data == ETH_SFD) begin
                    state_d     = DATA;
                    start_frame = 1'b1;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            DATA: begin
                if (rx_dv) begin
                    take_byte = 1'b1;
                end else begin
                    end_frame = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    crc32_d8_next u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .next_o (crc_next)
    );

    // A frame too short to hold an FCS can never be CRC-good, whatever the register holds.
    assign short_w   = (len_q < 16'd4);
    assign crc_bad_w = short_w || (crc_q != CRC_RESIDUE);
    assign len_bad_w = short_w || ((MIN_L != 16'd0) && (len_q < MIN_L)) || (len_q > MAX_L);
    assign ok_w      = !(crc_bad_w || len_bad_w || phy_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= WAIT_IDLE;
            crc_q          <= CRC_INIT;
            dly_q          <= '0;
            len_q          <= '0;
            phy_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            out_data_q     <= '0;
            status_valid_q <= 1'b0;
            frame_ok_q     <= 1'b0;
            crc_err_q      <= 1'b0;
            len_err_q      <= 1'b0;
            phy_err_q      <= 1'b0;
            frame_len_q    <= '0;
            good_q         <= '0;
            bad_q          <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            status_valid_q <= 1'b0;

            if (start_frame) begin
                crc_q <= CRC_INIT;
                len_q <= '0;
                phy_q <= 1'b0;
            end

            if (take_byte) begin
                crc_q <= crc_next;
                if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
                dly_q <= {dly_q[2:0], rx_data};
                if (rx_er) phy_q <= 1'b1;
                // Four bytes already held: the oldest is now known not to be FCS.
                if (len_q >= 16'd4) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= dly_q[3];
                    out_sof_q   <= (len_q == 16'd4);
                end
            end

            if (end_frame) begin
                status_valid_q <= 1'b1;
                frame_ok_q     <= ok_w;
                crc_err_q      <= crc_bad_w;
                len_err_q      <= len_bad_w;
                phy_err_q      <= phy_q;
                frame_len_q    <= len_q;
                if (ok_w && good_q != '1) good_q <= good_q + 1'b1;
                if (!ok_w && bad_q != '1) bad_q <= bad_q + 1'b1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_sof      = out_sof_q;
    assign status_valid = status_valid_q;
    assign frame_ok     = frame_ok_q;
    assign crc_err      = crc_err_q;
    assign len_err      = len_err_q;
    assign phy_err      = phy_err_q;
    assign frame_len    = frame_len_q;
    assign good_cnt     = good_q;
    assign bad_cnt      = bad_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench: dut_a (MIN_LEN=0, CNT_W=2) and dut_b (defaults) see the same RX stream.
module tb_eth_rx_fcs_check;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] rx_data = 8'h00;

    always #5 Clk = ~Clk;

    logic        a_out_valid, a_out_sof, a_status_valid, a_frame_ok, a_crc_err, a_len_err, a_phy_err;
    logic [7:0]  a_out_data;
    logic [15:0] a_frame_len;
    logic [1:0]  a_good_cnt, a_bad_cnt;
    logic        b_out_valid, b_out_sof, b_status_valid, b_frame_ok, b_crc_err, b_len_err, b_phy_err;
    logic [7:0]  b_out_data;
    logic [15:0] b_frame_len;
    logic [15:0] b_good_cnt, b_bad_cnt;

    eth_rx_fcs_check #(.MIN_LEN(0), .MAX_LEN(1518), .CNT_W(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_sof(a_out_sof),
        .status_valid(a_status_valid), .frame_ok(a_frame_ok), .crc_err(a_crc_err),
        .len_err(a_len_err), .phy_err(a_phy_err), .frame_len(a_frame_len),
        .good_cnt(a_good_cnt), .bad_cnt(a_bad_cnt)
    );

    eth_rx_fcs_check dut_b (
        .Clk(Clk), .Reset(Reset), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_sof(b_out_sof),
        .status_valid(b_status_valid), .frame_ok(b_frame_ok), .crc_err(b_crc_err),
        .len_err(b_len_err), .phy_err(b_phy_err), .frame_len(b_frame_len),
        .good_cnt(b_good_cnt), .bad_cnt(b_bad_cnt)
    );

    typedef struct packed {
        logic        ok;
        logic        crc;
        logic        len;
        logic        phy;
        logic [15:0] flen;
    } stat_t;

    // kind: 0 = ASCII "123456789", 1 = plen zero bytes, 2 = plen raw bytes with no FCS
    typedef struct {
        int          kind;
        int          plen;
        logic        bad_fcs;
        int          er_pos;
        logic        e_crc;
        logic        e_len_a;
        logic        e_len_b;
        logic        e_phy;
        int          e_flen;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [8:0]  oq0[$], oq1[$];
    stat_t       sq0[$], sq1[$];
    logic [7:0]  body[$];
    logic [7:0]  txq[$];
    int          exp_good[2] = '{0, 0};
    int          exp_bad[2]  = '{0, 0};
    vec_t        vecs[11];

    always @(negedge Clk) begin
        if (a_out_valid) oq0.push_back({a_out_sof, a_out_data});
        if (b_out_valid) oq1.push_back({b_out_sof, b_out_data});
        if (a_status_valid) sq0.push_back(stat_t'({a_frame_ok, a_crc_err, a_len_err, a_phy_err, a_frame_len}));
        if (b_status_valid) sq1.push_back(stat_t'({b_frame_ok, b_crc_err, b_len_err, b_phy_err, b_frame_len}));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference FCS in the reflected (LSB-first, EDB88320) formulation.
    function automatic logic [31:0] fcs_of();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (body[i]) begin
            c = c ^ {24'd0, body[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int kind, input int plen, input logic bad_fcs);
        logic [31:0] f;
        body.delete();
        txq.delete();
        if (kind == 0) for (int i = 0; i < 9; i++) body.push_back(8'(8'h31 + i));
        else if (kind == 1) for (int i = 0; i < plen; i++) body.push_back(8'h00);
        else for (int i = 0; i < plen; i++) body.push_back(8'(8'hA0 + i));
        if (kind != 2) begin
            f = fcs_of();
            body.push_back(f[7:0]);
            body.push_back(f[15:8]);
            body.push_back(f[23:16]);
            body.push_back(f[31:24]);
            if (bad_fcs) body[body.size()-1] = body[body.size()-1] ^ 8'h01;
        end
        for (int i = 0; i < 7; i++) txq.push_back(8'h55);
        txq.push_back(8'hD5);
        foreach (body[i]) txq.push_back(body[i]);
    endtask

    task automatic drive_txq(input int er_pos, input int gap);
        for (int i = 0; i < txq.size(); i++) begin
            @(posedge Clk); #1;
            rx_dv   = 1'b1;
            rx_data = txq[i];
            rx_er   = (er_pos >= 0) && (i == er_pos + 8);
        end
        @(posedge Clk); #1;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
        repeat (gap) @(posedge Clk);
    endtask

    task automatic clear_q();
        oq0.delete(); oq1.delete(); sq0.delete(); sq1.delete();
    endtask

    task automatic count_frame(input int d, input logic ok);
        int mx = (d == 0) ? 3 : 65535;
        if (ok) begin if (exp_good[d] < mx) exp_good[d]++; end
        else begin if (exp_bad[d] < mx) exp_bad[d]++; end
    endtask

    task automatic chk_counters(input string tag, input int d);
        chk($sformatf("%s.d%0d.good_cnt", tag, d), (d == 0) ? {30'd0, a_good_cnt} : {16'd0, b_good_cnt}, exp_good[d]);
        chk($sformatf("%s.d%0d.bad_cnt", tag, d), (d == 0) ? {30'd0, a_bad_cnt} : {16'd0, b_bad_cnt}, exp_bad[d]);
    endtask

    task automatic check_dut(input int idx, input int d, input vec_t v, input int pay_n);
        logic [8:0] o[$];
        stat_t      s[$];
        logic       e_len, e_ok;
        int         bad_bytes = 0;
        int         sofs = 0;
        string      t = $sformatf("v%0d.d%0d", idx, d);
        if (d == 0) begin o = oq0; s = sq0; end else begin o = oq1; s = sq1; end
        e_len = (d == 0) ? v.e_len_a : v.e_len_b;
        e_ok  = !(v.e_crc || e_len || v.e_phy);
        chk({t, ".status_count"}, s.size(), 1);
        if (s.size() > 0) begin
            chk({t, ".frame_ok"}, {31'd0, s[0].ok}, {31'd0, e_ok});
            chk({t, ".crc_err"}, {31'd0, s[0].crc}, {31'd0, v.e_crc});
            chk({t, ".len_err"}, {31'd0, s[0].len}, {31'd0, e_len});
            chk({t, ".phy_err"}, {31'd0, s[0].phy}, {31'd0, v.e_phy});
            chk({t, ".frame_len"}, {16'd0, s[0].flen}, v.e_flen);
        end
        chk({t, ".out_count"}, o.size(), pay_n);
        foreach (o[i]) begin
            if (o[i][8]) sofs++;
            if (i < pay_n && (o[i][8] != (i == 0) || o[i][7:0] !== body[i])) bad_bytes++;
        end
        chk({t, ".out_bytes_bad"}, bad_bytes, 0);
        chk({t, ".sof_count"}, sofs, (pay_n > 0) ? 1 : 0);
        count_frame(d, e_ok);
        chk_counters(t, d);
    endtask

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        int   pay_n;
        build(v.kind, v.plen, v.bad_fcs);
        pay_n = (body.size() >= 4) ? body.size() - 4 : 0;
        clear_q();
        drive_txq(v.er_pos, 12);
        @(negedge Clk);
        check_dut(idx, 0, v, pay_n);
        check_dut(idx, 1, v, pay_n);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".a_flags"}, {17'd0, a_out_valid, a_out_data, a_out_sof, a_status_valid,
                                a_frame_ok, a_crc_err, a_len_err, a_phy_err}, 0);
        chk({tag, ".a_len_cnt"}, {12'd0, a_frame_len, a_good_cnt, a_bad_cnt}, 0);
        chk({tag, ".b_flags"}, {17'd0, b_out_valid, b_out_data, b_out_sof, b_status_valid,
                                b_frame_ok, b_crc_err, b_len_err, b_phy_err}, 0);
        chk({tag, ".b_len"}, {16'd0, b_frame_len}, 0);
        chk({tag, ".b_cnt"}, {b_good_cnt, b_bad_cnt}, 0);
    endtask

    initial begin
        //            kind plen bad er  crc len_a len_b phy flen
        vecs[0]  = '{0,    9,   0, -1,  0,  0,    1,    0,  13};
        vecs[1]  = '{0,    9,   1, -1,  1,  0,    1,    0,  13};
        vecs[2]  = '{1,   60,   0, -1,  0,  0,    0,    0,  64};
        vecs[3]  = '{1,   59,   0, -1,  0,  0,    1,    0,  63};
        vecs[4]  = '{0,    9,   0,  4,  0,  0,    1,    1,  13};
        vecs[5]  = '{2,    2,   0, -1,  1,  1,    1,    0,   2};
        vecs[6]  = '{2,    3,   0, -1,  1,  1,    1,    0,   3};
        vecs[7]  = '{2,    0,   0, -1,  1,  1,    1,    0,   0};
        vecs[8]  = '{1,    0,   0, -1,  0,  0,    1,    0,   4};
        vecs[9]  = '{1, 1514,   0, -1,  0,  0,    0,    0, 1518};
        vecs[10] = '{1, 1515,   0, -1,  0,  1,    1,    0, 1519};

        repeat (3) @(negedge Clk);
        reset_chk("reset");
        Reset = 1'b0;
        repeat (4) @(posedge Clk);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset in the middle of DATA with rx_dv held high, then a tail that must be ignored.
        txq.delete();
        for (int i = 0; i < 7; i++) txq.push_back(8'h55);
        txq.push_back(8'hD5);
        for (int i = 0; i < 10; i++) txq.push_back(8'h5A);
        foreach (txq[i]) begin
            @(posedge Clk); #1;
            rx_dv = 1'b1; rx_data = txq[i]; rx_er = 1'b0;
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        reset_chk("midrst");
        clear_q();
        exp_good = '{0, 0};
        exp_bad  = '{0, 0};
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(posedge Clk);
        #1 rx_dv = 1'b0;
        repeat (12) @(posedge Clk);
        @(negedge Clk);
        chk("midrst.out_after", oq0.size() + oq1.size(), 0);
        chk("midrst.status_after", sq0.size() + sq1.size(), 0);
        run_vec(0);

        // Zero-IFG stream: good, good, broken preamble, good, good.
        clear_q();
        build(1, 60, 0); drive_txq(-1, 0);
        build(1, 60, 0); drive_txq(-1, 0);
        txq.delete();
        txq.push_back(8'h55); txq.push_back(8'h55); txq.push_back(8'h12);
        for (int i = 0; i < 5; i++) txq.push_back(8'h55);
        txq.push_back(8'hD5);
        for (int i = 0; i < 9; i++) txq.push_back(8'(8'h31 + i));
        drive_txq(-1, 0);
        build(1, 60, 0); drive_txq(-1, 0);
        build(1, 60, 0); drive_txq(-1, 12);
        @(negedge Clk);
        begin
            int oks0 = 0;
            int oks1 = 0;
            foreach (sq0[i]) if (sq0[i].ok && sq0[i].flen == 16'd64) oks0++;
            foreach (sq1[i]) if (sq1[i].ok && sq1[i].flen == 16'd64) oks1++;
            chk("b2b.d0.status_count", sq0.size(), 4);
            chk("b2b.d1.status_count", sq1.size(), 4);
            chk("b2b.d0.ok64", oks0, 4);
            chk("b2b.d1.ok64", oks1, 4);
            chk("b2b.d0.out_count", oq0.size(), 240);
            chk("b2b.d1.out_count", oq1.size(), 240);
        end
        for (int k = 0; k < 4; k++) begin
            count_frame(0, 1'b1);
            count_frame(1, 1'b1);
        end
        chk_counters("b2b", 0);
        chk_counters("b2b", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
